// File: rtl/seg_pair_encoder.sv
// seg_pair_encoder: serial double-dabble binary-to-BCD conversion for a two-digit
// display pair, producing registered active-low {dp,g,f,e,d,c,b,a} patterns.
module seg_pair_encoder #(
  parameter int BIN_W         = 7,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [7:0]       hex_hi,
  output logic [7:0]       hex_lo
);

  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [BIN_W-1:0] shreg;
  logic [7:0]       bcd;
  logic [7:0]       bcd_adj;
  logic [7:0]       bin_ext;
  logic             oor;
  logic             bin_oor;

  // Active-low segment pattern for one decimal digit; non-digits render blank.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

  assign bin_ext = 8'(bin);
  assign bin_oor = (bin_ext > 8'd99);
  assign ready   = (state == IDLE);

  // Add-3 correction applied to each BCD nibble before it is shifted.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: out-of-range values skip the shift phase entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bin_oor ? LOAD : SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture, serial shift-and-add-3, and registered display update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      oor    <= 1'b0;
      hex_hi <= '1;
      hex_lo <= '1;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            bcd   <= '0;
            oor   <= bin_oor;
            cnt   <= bin_oor ? '0 : CW'(BIN_W);
          end
        end
        SHIFT: begin
          // {bcd, shreg} << 1 after correction; bcd[7] would be a hundreds bit and is dropped.
          bcd   <= {bcd_adj[6:0], shreg[BIN_W-1]};
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
        end
        LOAD: begin
          done <= 1'b1;
          err  <= oor;
          if (oor) begin
            hex_hi <= 8'hBF;
            hex_lo <= 8'hBF;
          end else begin
            hex_lo <= seg7(bcd[3:0]);
            if ((BLANK_LEADING != 0) && (bcd[7:4] == 4'd0)) hex_hi <= 8'hFF;
            else                                            hex_hi <= seg7(bcd[7:4]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_pair_encoder.sv
// Testbench for seg_pair_encoder: two instances (leading blank on / off) share
// the same stimulus and are checked against a decimal-arithmetic reference model.
module tb_seg_pair_encoder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] bin;
  logic       ready1, done1, err1;
  logic [7:0] hex_hi1, hex_lo1;
  logic       ready0, done0, err0;
  logic [7:0] hex_hi0, hex_lo0;

  int unsigned n_checks;
  int unsigned n_fail;

  localparam logic [7:0] PAT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_pair_encoder #(.BIN_W(7), .BLANK_LEADING(1)) u_blank (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready1), .done(done1), .err(err1), .hex_hi(hex_hi1), .hex_lo(hex_lo1)
  );

  seg_pair_encoder #(.BIN_W(7), .BLANK_LEADING(0)) u_zero (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready0), .done(done0), .err(err0), .hex_hi(hex_hi0), .hex_lo(hex_lo0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One full request: accept, latency, busy behaviour, results, done pulse width.
  task automatic run_conversion(input int unsigned v);
    logic [7:0]  e_hi1, e_hi0, e_lo, prev_hi, prev_lo;
    logic        e_err;
    int unsigned e_lat, lat;
    bit          busy_ok;
    if (v > 99) begin
      e_hi1 = 8'hBF; e_hi0 = 8'hBF; e_lo = 8'hBF; e_err = 1'b1; e_lat = 1;
    end else begin
      e_lo  = PAT[v % 10];
      e_hi0 = PAT[v / 10];
      e_hi1 = (v / 10 == 0) ? 8'hFF : PAT[v / 10];
      e_err = 1'b0;
      e_lat = 8;
    end
    @(negedge clk);
    n_checks++;
    if (ready1 !== 1'b1) begin
      n_fail++; $display("FAIL ready_before v=%0d got %b want 1", v, ready1);
    end
    prev_hi = hex_hi1; prev_lo = hex_lo1;
    start = 1'b1; bin = 7'(v);
    @(posedge clk); #1;
    start = 1'b0; bin = 7'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (done1 !== 1'b1 && lat < 20) begin
      if (ready1 !== 1'b0 || hex_hi1 !== prev_hi || hex_lo1 !== prev_lo) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != e_lat) begin
      n_fail++; $display("FAIL latency v=%0d got %0d want %0d", v, lat, e_lat);
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++; $display("FAIL busy_hold v=%0d got ready/outputs changing want stable", v);
    end
    n_checks++;
    if (hex_hi1 !== e_hi1 || hex_lo1 !== e_lo) begin
      n_fail++; $display("FAIL hex_blank v=%0d got %h/%h want %h/%h", v, hex_hi1, hex_lo1, e_hi1, e_lo);
    end
    n_checks++;
    if (hex_hi0 !== e_hi0 || hex_lo0 !== e_lo) begin
      n_fail++; $display("FAIL hex_zero v=%0d got %h/%h want %h/%h", v, hex_hi0, hex_lo0, e_hi0, e_lo);
    end
    n_checks++;
    if (err1 !== e_err || err0 !== e_err) begin
      n_fail++; $display("FAIL err v=%0d got %b/%b want %b", v, err1, err0, e_err);
    end
    n_checks++;
    if (done0 !== 1'b1 || ready1 !== 1'b1) begin
      n_fail++; $display("FAIL done_ready v=%0d got done0=%b ready=%b want 1/1", v, done0, ready1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done1 !== 1'b0 || hex_hi1 !== e_hi1 || hex_lo1 !== e_lo || err1 !== e_err) begin
      n_fail++;
      $display("FAIL done_pulse_hold v=%0d got done=%b %h/%h err=%b want 0 %h/%h err=%b",
               v, done1, hex_hi1, hex_lo1, err1, e_hi1, e_lo, e_err);
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (hex_hi1 !== 8'hFF || hex_lo1 !== 8'hFF || ready1 !== 1'b1 || done1 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_init got %h/%h r=%b d=%b e=%b want FF/FF 1 0 0",
                         hex_hi1, hex_lo1, ready1, done1, err1);
    end
    @(negedge clk); rst = 1'b0;
    run_conversion(127);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    n_checks++;
    if (hex_hi1 !== 8'hFF || hex_lo1 !== 8'hFF || ready1 !== 1'b1 || done1 !== 1'b0 || err1 !== 1'b0
        || hex_hi0 !== 8'hFF || err0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_async got %h/%h r=%b d=%b e=%b want FF/FF 1 0 0",
                         hex_hi1, hex_lo1, ready1, done1, err1);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_conv42;
    run_conversion(42);
  endtask

  task automatic test_blanking;
    run_conversion(7);
    run_conversion(0);
    run_conversion(99);
    run_conversion(10);
  endtask

  task automatic test_out_of_range;
    run_conversion(100);
    run_conversion(127);
    run_conversion(5);
  endtask

  task automatic test_busy;
    int unsigned nd;
    logic [7:0]  got_hi, got_lo;
    @(negedge clk); start = 1'b1; bin = 7'd58;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; bin = 7'd13;
    @(negedge clk); start = 1'b0;
    nd = 0; got_hi = 8'h00; got_lo = 8'h00;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin
        nd++;
        if (nd == 1) begin got_hi = hex_hi1; got_lo = hex_lo1; end
      end
    end
    n_checks++;
    if (nd != 1) begin
      n_fail++; $display("FAIL busy_done_count got %0d want 1", nd);
    end
    n_checks++;
    if (got_hi !== 8'h92 || got_lo !== 8'h80) begin
      n_fail++; $display("FAIL busy_result got %h/%h want 92/80", got_hi, got_lo);
    end
  endtask

  task automatic test_reset_mid;
    int unsigned nd;
    @(negedge clk); start = 1'b1; bin = 7'd88;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst = 1'b1; #1;
    n_checks++;
    if (hex_hi1 !== 8'hFF || hex_lo1 !== 8'hFF || ready1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got %h/%h r=%b d=%b want FF/FF 1 0",
                         hex_hi1, hex_lo1, ready1, done1);
    end
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) nd++;
    end
    n_checks++;
    if (nd != 0) begin
      n_fail++; $display("FAIL reset_mid_no_done got %0d done pulses want 0", nd);
    end
    run_conversion(31);
  endtask

  task automatic test_back_to_back;
    int unsigned nd, last;
    @(negedge clk); bin = 7'd63; start = 1'b1;
    nd = 0; last = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin
        if (nd > 0) begin
          n_checks++;
          if (i - last != 9) begin
            n_fail++; $display("FAIL b2b_period got %0d want 9", i - last);
          end
        end
        n_checks++;
        if (hex_hi1 !== 8'h82 || hex_lo1 !== 8'hB0) begin
          n_fail++; $display("FAIL b2b_result got %h/%h want 82/B0", hex_hi1, hex_lo1);
        end
        nd++; last = i;
      end
    end
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (nd != 4) begin
      n_fail++; $display("FAIL b2b_count got %0d want 4", nd);
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) run_conversion($urandom_range(127, 0));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; bin = '0;
    test_reset();
    test_conv42();
    test_blanking();
    test_out_of_range();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
